// File: rtl/ra_sample_sequencer.sv
// ra_sample_sequencer
//   Control block for the rolling-average datapath. It synchronizes the pin
//   strobe and edge-detects it. For each accepted sample it captures the
//   value, pulses the shift line, pulses the averager start, waits out the
//   averager latency, then latches the average. It also tracks window fill.
//   One extra strobe arriving during a sequence is held in a 1-deep pending
//   slot. Any further strobe arriving while that slot is full is dropped.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   i_data_clk      asynchronous sample strobe from the pin
//   i_value         sample, stable while i_data_clk is high
//   i_ra            averager result, valid CALC_LATENCY cycles after start
//   o_shift_en      1-cycle pulse: shift o_value into the line
//   o_value         registered captured sample
//   o_start_calc    1-cycle pulse to the averager
//   o_ra            held average result
//   o_valid         sticky: o_ra covers a full RA_SIZE window
//   o_busy          sequence in progress
//   o_fill          samples accepted, saturating at RA_SIZE
//   o_overrun       sticky dropped-strobe flag
//
// Build option
//   RA_SEQ_OVERRUN_EN  when defined, o_overrun latches on any dropped edge.
//                      When undefined, o_overrun is tied low.

module ra_sample_sequencer #(
  parameter int BITS_PER_ELEM = 5,
  parameter int RA_SIZE       = 8,
  parameter int CALC_LATENCY  = 2,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_data_clk,
  input  logic [BITS_PER_ELEM-1:0]         i_value,
  input  logic [BITS_PER_ELEM-1:0]         i_ra,
  output logic                             o_shift_en,
  output logic [BITS_PER_ELEM-1:0]         o_value,
  output logic                             o_start_calc,
  output logic [BITS_PER_ELEM-1:0]         o_ra,
  output logic                             o_valid,
  output logic                             o_busy,
  output logic [$clog2(RA_SIZE+1)-1:0]     o_fill,
  output logic                             o_overrun
);

  localparam int FILL_W = $clog2(RA_SIZE+1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(RA_SIZE);
  localparam logic [3:0]        LAT      = 4'(CALC_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CALC,
    S_WAIT,
    S_UPDATE
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic [3:0]                 r_cnt, w_cnt_nxt;
  logic [SYNC_STAGES-1:0]     r_sync;
  logic                       r_prev;
  logic                       w_edge;
  logic                       w_update;
  logic                       r_pend_vld;
  logic [BITS_PER_ELEM-1:0]   r_pend_val;
  logic [BITS_PER_ELEM-1:0]   r_value;
  logic [BITS_PER_ELEM-1:0]   r_ra;
  logic [FILL_W-1:0]          r_fill;
  logic                       r_valid;

  // Synchronizer and edge detect. The chain clears on reset, so a strobe
  // that is already high when reset releases still produces one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_data_clk};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_busy = (r_state != S_IDLE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FSM next state and pulse outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    o_shift_en   = 1'b0;
    o_start_calc = 1'b0;
    w_update     = 1'b0;
    case (r_state)
      S_IDLE:   if (r_pend_vld || w_edge) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        o_shift_en  = 1'b1;
        w_state_nxt = S_CALC;
      end
      S_CALC: begin
        o_start_calc = 1'b1;
        w_cnt_nxt    = LAT;
        w_state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        // Counter holds the remaining WAIT cycles, including this one.
        if (r_cnt <= 4'd1) w_state_nxt = S_UPDATE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_UPDATE: begin
        w_update    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Capture and pending slot. In IDLE, the pending sample is served before
  // a new edge. A simultaneous edge then refills the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value    <= '0;
      r_pend_vld <= 1'b0;
      r_pend_val <= '0;
    end else if (r_state == S_IDLE) begin
      if (r_pend_vld) begin
        r_value    <= r_pend_val;
        r_pend_vld <= w_edge;
        if (w_edge) r_pend_val <= i_value;
      end else if (w_edge) begin
        r_value <= i_value;
      end
    end else if (w_edge && !r_pend_vld) begin
      r_pend_vld <= 1'b1;
      r_pend_val <= i_value;
    end
  end

  // Result, fill and window-full tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ra    <= '0;
      r_fill  <= '0;
      r_valid <= 1'b0;
    end else if (w_update) begin
      r_ra <= i_ra;
      if (r_fill != FILL_MAX) r_fill <= r_fill + 1'b1;
      if (r_fill >= FILL_MAX - 1'b1) r_valid <= 1'b1;
    end
  end

  assign o_value = r_value;
  assign o_ra    = r_ra;
  assign o_fill  = r_fill;
  assign o_valid = r_valid;

`ifdef RA_SEQ_OVERRUN_EN
  logic w_drop;
  logic r_overrun;

  assign w_drop = w_edge & o_busy & r_pend_vld;

  always_ff @(posedge clk) begin
    if (rst)         r_overrun <= 1'b0;
    else if (w_drop) r_overrun <= 1'b1;
  end

  assign o_overrun = r_overrun;
`else
  assign o_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_ra_sample_sequencer.sv
module tb_ra_sample_sequencer;
  localparam int W    = 5;
  localparam int RA   = 8;
  localparam int L    = 2;
  localparam int SS   = 2;
  localparam int P    = L + 4;   // edge-to-edge service period
  localparam int MAXC = 400;
`ifdef RA_SEQ_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         i_data_clk;
  logic [W-1:0] i_value, i_ra;
  logic         o_shift_en, o_start_calc, o_valid, o_busy, o_overrun;
  logic [W-1:0] o_value, o_ra;
  logic [3:0]   o_fill;

  ra_sample_sequencer #(.BITS_PER_ELEM(W), .RA_SIZE(RA), .CALC_LATENCY(L), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .i_data_clk(i_data_clk), .i_value(i_value), .i_ra(i_ra),
    .o_shift_en(o_shift_en), .o_value(o_value), .o_start_calc(o_start_calc), .o_ra(o_ra),
    .o_valid(o_valid), .o_busy(o_busy), .o_fill(o_fill), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int n_shift, n_sc;

  // per-cycle stimulus and expectation arrays
  bit           s_strb[MAXC];
  logic [W-1:0] s_val[MAXC], s_ra[MAXC];
  bit           e_shift[MAXC], e_sc[MAXC], e_busy[MAXC], e_valid[MAXC], e_ovr[MAXC];
  logic [W-1:0] e_value[MAXC], e_ra[MAXC];
  logic [3:0]   e_fill[MAXC];
  bit           ev_v[MAXC], ev_u[MAXC], ev_vl[MAXC];
  logic [W-1:0] ev_vv[MAXC], ev_ra[MAXC];
  logic [3:0]   ev_f[MAXC];

  typedef struct {
    logic         strb;
    logic [W-1:0] val, ra;
    logic         shift, sc, busy, valid;
    logic [W-1:0] value, ra_o;
    logic [3:0]   fill;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; i_data_clk = 1'b0; i_value = '0; i_ra = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic clr(input int n);
    for (int c = 0; c < n; c++) begin
      s_strb[c] = 1'b0; s_val[c] = '0; s_ra[c] = '0;
    end
  endtask

  // Transaction-level model: each accepted sample occupies the block for P
  // cycles starting at its capture cycle S (shift at S+1, start at S+2,
  // result visible at S+P with i_ra as driven at S+P-1). A sample that
  // arrives while busy waits for the previous one to finish. It is dropped
  // if another sample is already waiting.
  task automatic model(input int n);
    int last, ovr_from, s, u, k;
    int sidx[$];
    logic [W-1:0] svals[$];
    logic [W-1:0] cv, cr;
    logic [3:0] cf;
    bit cl, edge_c, prev_c;
    last = -1000; ovr_from = MAXC + 10;
    for (int c = 0; c < MAXC; c++) begin
      e_shift[c] = 0; e_sc[c] = 0; e_busy[c] = 0;
      ev_v[c] = 0; ev_u[c] = 0; ev_vl[c] = 0; ev_vv[c] = '0; ev_ra[c] = '0; ev_f[c] = '0;
    end
    for (int c = 0; c < n; c++) begin
      prev_c = (c - SS - 1 >= 0) ? s_strb[c-SS-1] : 1'b0;
      edge_c = (c >= SS) ? (s_strb[c-SS] && !prev_c) : 1'b0;
      if (edge_c) begin
        if (last > c) begin
          if (c + 1 < ovr_from) ovr_from = c + 1;
        end else begin
          s = (c >= last + P) ? c : last + P;
          sidx.push_back(s); svals.push_back(s_val[c]);
          last = s;
        end
      end
    end
    for (k = 0; k < sidx.size(); k++) begin
      s = sidx[k];
      if (s + 1 < n) begin e_shift[s+1] = 1; ev_v[s+1] = 1; ev_vv[s+1] = svals[k]; end
      if (s + 2 < n) e_sc[s+2] = 1;
      for (int b = s + 1; b <= s + 3 + L; b++) if (b < n) e_busy[b] = 1;
      u = s + 3 + L;
      if (u + 1 < n) begin
        ev_u[u+1] = 1; ev_ra[u+1] = s_ra[u];
        ev_f[u+1] = 4'((k + 1 > RA) ? RA : k + 1);
        ev_vl[u+1] = (k + 1 >= RA);
      end
    end
    cv = '0; cr = '0; cf = '0; cl = 0;
    for (int c = 0; c < n; c++) begin
      if (ev_v[c]) cv = ev_vv[c];
      if (ev_u[c]) begin cr = ev_ra[c]; cf = ev_f[c]; cl = ev_vl[c]; end
      e_value[c] = cv; e_ra[c] = cr; e_fill[c] = cf; e_valid[c] = cl;
      e_ovr[c] = OVR_EN && (c >= ovr_from);
    end
  endtask

  // Apply arrays from cycle 0 (right after reset) and compare each cycle.
  task automatic run(input int n, input string tag);
    logic [23:0] act, exp;
    n_shift = 0; n_sc = 0;
    for (int c = 0; c < n; c++) begin
      i_data_clk = s_strb[c]; i_value = s_val[c]; i_ra = s_ra[c];
      @(negedge clk);
      act = {o_shift_en, o_start_calc, o_busy, o_valid, o_overrun, o_value, o_ra, o_fill};
      exp = {e_shift[c], e_sc[c], e_busy[c], e_valid[c], e_ovr[c], e_value[c], e_ra[c], e_fill[c]};
      chk($sformatf("%s cycle %0d {shift,sc,busy,valid,ovr,value,ra,fill}", tag, c), act, exp);
      if (o_shift_en) n_shift++;
      if (o_start_calc) n_sc++;
      if (o_shift_en && o_start_calc) chk($sformatf("%s cycle %0d both pulses", tag, c), 1, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int c, lo, hi;
    // single strobe, value 17, averager result 9; edge lands on cycle 2
    for (int i = 0; i < 10; i++)
      tbl[i] = '{(i < 2), 5'd17, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 4'd0};
    tbl[3].shift = 1; tbl[4].sc = 1;
    for (int i = 3; i <= 7; i++) tbl[i].busy = 1;
    for (int i = 3; i <= 9; i++) tbl[i].value = 5'd17;
    for (int i = 8; i <= 9; i++) begin tbl[i].ra_o = 5'd9; tbl[i].fill = 4'd1; end

    do_reset();
    for (int i = 0; i < 10; i++) begin
      i_data_clk = tbl[i].strb; i_value = tbl[i].val; i_ra = tbl[i].ra;
      @(negedge clk);
      chk($sformatf("tbl%0d shift", i), o_shift_en, tbl[i].shift);
      chk($sformatf("tbl%0d start_calc", i), o_start_calc, tbl[i].sc);
      chk($sformatf("tbl%0d busy", i), o_busy, tbl[i].busy);
      chk($sformatf("tbl%0d value", i), o_value, tbl[i].value);
      chk($sformatf("tbl%0d ra", i), o_ra, tbl[i].ra_o);
      chk($sformatf("tbl%0d fill", i), o_fill, tbl[i].fill);
      chk($sformatf("tbl%0d valid", i), o_valid, tbl[i].valid);
      chk($sformatf("tbl%0d overrun", i), o_overrun, 0);
      @(posedge clk); #1;
    end

    // nine strobes 20 cycles apart: fill saturates, valid rises on the 8th
    clr(190);
    for (int k = 0; k < 9; k++) begin s_strb[20*k] = 1; s_strb[20*k+1] = 1; end
    for (int i = 0; i < 190; i++) begin s_val[i] = 5'(i); s_ra[i] = 5'($urandom_range(0, 31)); end
    model(190); do_reset(); run(190, "nine");
    chk("nine shift pulses", n_shift, 9);
    chk("nine final fill", o_fill, 8);
    chk("nine final valid", o_valid, 1);

    // second strobe (value 3) arrives during WAIT of the first
    clr(30);
    s_strb[0] = 1; s_strb[1] = 1; s_strb[3] = 1; s_strb[4] = 1;
    for (int i = 0; i < 30; i++) begin s_val[i] = (i < 3) ? 5'd4 : 5'd3; s_ra[i] = 5'd11; end
    model(30); do_reset(); run(30, "wait2");
    chk("wait2 shift pulses", n_shift, 2);
    chk("wait2 last value", o_value, 3);
    chk("wait2 overrun", o_overrun, 0);

    // three strobes two cycles apart: third is dropped
    clr(30);
    s_strb[0] = 1; s_strb[2] = 1; s_strb[4] = 1;
    for (int i = 0; i < 30; i++) begin
      s_val[i] = (i <= 2) ? 5'd1 : (i <= 4) ? 5'd2 : 5'd3;
      s_ra[i] = 5'd7;
    end
    model(30); do_reset(); run(30, "drop");
    chk("drop shift pulses", n_shift, 2);
    chk("drop last value", o_value, 2);
    chk("drop overrun", o_overrun, OVR_EN);

    // strobe held high for 50 cycles
    clr(80);
    for (int i = 0; i < 50; i++) s_strb[i] = 1;
    for (int i = 0; i < 80; i++) begin s_val[i] = 5'd21; s_ra[i] = 5'd5; end
    model(80); do_reset(); run(80, "held");
    chk("held shift pulses", n_shift, 1);
    chk("held start pulses", n_sc, 1);

    // randomized strobe trains
    for (int r = 0; r < 3; r++) begin
      clr(300);
      c = 0;
      while (c < 300) begin
        lo = $urandom_range(1, 12); c += lo;
        hi = $urandom_range(1, 3);
        for (int j = 0; j < hi; j++) begin if (c < 300) s_strb[c] = 1; c++; end
      end
      for (int i = 0; i < 300; i++) begin
        s_val[i] = 5'($urandom_range(0, 31)); s_ra[i] = 5'($urandom_range(0, 31));
      end
      model(300); do_reset(); run(300, $sformatf("rand%0d", r));
    end

    // reset during WAIT with a pending sample queued
    clr(22);
    s_strb[0] = 1; s_strb[1] = 1; s_strb[16] = 1; s_strb[19] = 1;
    for (int i = 0; i < 22; i++) begin s_val[i] = 5'd13; s_ra[i] = 5'd9; end
    model(22); do_reset(); run(22, "rstw");
    chk("rstw in WAIT before reset", o_busy, 1);
    rst = 1'b1; i_data_clk = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstw busy", o_busy, 0);
    chk("rstw ra", o_ra, 0);
    chk("rstw fill", o_fill, 0);
    chk("rstw valid", o_valid, 0);
    chk("rstw value", o_value, 0);
    chk("rstw overrun", o_overrun, 0);
    n_shift = 0; n_sc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_shift_en) n_shift++;
      if (o_start_calc) n_sc++;
    end
    chk("rstw shift after reset", n_shift, 0);
    chk("rstw start after reset", n_sc, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
